// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } state_e;

  localparam logic PortCpu = 1'b0;
  localparam logic PortLdr = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the pointer.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic valid_o,
  output logic winner_o,
  output logic next_ptr_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      winner_o = ptr_i;
    end else if (req1_i) begin
      winner_o = PortLdr;
    end else begin
      winner_o = PortCpu;
    end
    // Any win hands preference to the other port.
    next_ptr_o = valid_o ? ~winner_o : ptr_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between the CPU (port 0) and a loader/debug master (port 1)
// with a registered req/gnt/done handshake; one access every two cycles back to back.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADRBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               we0,
  input  logic [ADRBITS-1:0] adr0,
  input  logic [WIDTH-1:0]   wdata0,
  output logic               gnt0,
  output logic               done0,
  input  logic               req1,
  input  logic               we1,
  input  logic [ADRBITS-1:0] adr1,
  input  logic [WIDTH-1:0]   wdata1,
  output logic               gnt1,
  output logic               done1,
  output logic [WIDTH-1:0]   rdata,
  output logic [ADRBITS-1:0] mem_adr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               mem_we,
  input  logic [WIDTH-1:0]   mem_rdata
);

  state_e state_q;
  logic   ptr_q;
  logic   win_q;
  logic   we_q;

  logic               pick_valid;
  logic               pick_winner;
  logic               pick_next_ptr;
  logic               sel_we;
  logic [ADRBITS-1:0] sel_adr;
  logic [WIDTH-1:0]   sel_wdata;

  rr_pick2 u_pick (
    .req0_i     (req0),
    .req1_i     (req1),
    .ptr_i      (ptr_q),
    .valid_o    (pick_valid),
    .winner_o   (pick_winner),
    .next_ptr_o (pick_next_ptr)
  );

  always_comb begin
    sel_we    = (pick_winner == PortLdr) ? we1 : we0;
    sel_adr   = (pick_winner == PortLdr) ? adr1 : adr0;
    sel_wdata = (pick_winner == PortLdr) ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= PortCpu;
      win_q     <= PortCpu;
      we_q      <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      mem_we <= 1'b0;
      case (state_q)
        StAccess: begin
          state_q <= StResp;
          done0   <= (win_q == PortCpu);
          done1   <= (win_q == PortLdr);
        end
        // Idle and Resp arbitrate identically; the unused encoding recovers the same way.
        default: begin
          if (pick_valid) begin
            state_q   <= StAccess;
            win_q     <= pick_winner;
            ptr_q     <= pick_next_ptr;
            we_q      <= sel_we;
            mem_adr   <= sel_adr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            gnt0      <= (pick_winner == PortCpu);
            gnt1      <= (pick_winner == PortLdr);
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign rdata = (state_q == StResp && !we_q) ? mem_rdata : '0;

endmodule
